// File: rtl/spi_pkg.sv
// Shared constants for the mode-selectable SPI slave: {CPOL,CPHA} mode codes and FSM encoding.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  function automatic logic [1:0] spi_mode(input logic cpol, input logic cpha);
    return {cpol, cpha};
  endfunction

endpackage

// File: rtl/spi_slave_mode_sync.sv
// N-stage synchroniser for one asynchronous SPI pin; resets to the pin's idle level.
module spi_sync
  import spi_pkg::*;
#(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sr <= {STAGES{RESET_VAL}};
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/spi_slave_mode.sv
// SPI slave with selectable CPOL/CPHA, bit order and word width, oversampled in the clk domain.
module spi_slave_mode
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             ss,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_wr,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int              CW          = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST        = CW'(WIDTH - 1);
  localparam logic [1:0]      MODE        = spi_mode(CPOL, CPHA);
  localparam bit              SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

  logic             sclk_s, mosi_s, ss_s, sclk_d;
  logic             lead_edge, trail_edge, sample_edge, shift_edge;
  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rx_sr, tx_sr, hold_q, load_word;
  logic             hold_full, done_p, start, word_end, load;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] w, input logic b);
    return MSB_FIRST ? {w[WIDTH-2:0], b} : {b, w[WIDTH-1:1]};
  endfunction

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(ss), .q(ss_s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sclk_d <= CPOL;
    else      sclk_d <= sclk_s;
  end

  always_comb begin
    lead_edge   = (sclk_d == CPOL) && (sclk_s != CPOL);
    trail_edge  = (sclk_d != CPOL) && (sclk_s == CPOL);
    sample_edge = SAMPLE_LEAD ? lead_edge  : trail_edge;
    shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;
    start       = (state == ST_IDLE) && !ss_s;
    word_end    = (state == ST_ACTIVE) && !ss_s && sample_edge && (cnt == LAST);
    load        = start || word_end;
    load_word   = hold_full ? hold_q : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rx_sr  <= '0;
      tx_sr  <= '0;
      miso   <= 1'b0;
      done_p <= 1'b0;
    end else begin
      done_p <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!ss_s) begin
            state <= ST_ACTIVE;
            cnt   <= '0;
            tx_sr <= load_word;
            miso  <= CPHA ? 1'b0 : first_bit(load_word);
          end
        end
        default: begin
          if (ss_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rx_sr <= '0;
            tx_sr <= '0;
            miso  <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_sr <= shift_in(rx_sr, mosi_s);
              if (cnt == LAST) begin
                cnt    <= '0;
                done_p <= 1'b1;
                tx_sr  <= load_word;
                if (!CPHA) miso <= first_bit(load_word);
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            // CPHA=0: a trailing edge with cnt==0 can only follow a completed word, whose
            // reload already put the next first bit on miso.
            if (shift_edge) begin
              if (CPHA) begin
                miso  <= first_bit(tx_sr);
                tx_sr <= shift_out(tx_sr);
              end else if (cnt != '0) begin
                miso  <= first_bit(shift_out(tx_sr));
                tx_sr <= shift_out(tx_sr);
              end
            end
          end
        end
      endcase
    end
  end

  // A write coinciding with a load refills the hold even though tx_ready reads 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= '0;
      hold_full <= 1'b0;
    end else if (load) begin
      if (tx_wr) begin
        hold_q    <= tx_data;
        hold_full <= 1'b1;
      end else begin
        hold_full <= 1'b0;
      end
    end else if (tx_wr && !hold_full) begin
      hold_q    <= tx_data;
      hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else if (done_p) begin
      rx_data    <= rx_sr;
      rx_valid   <= 1'b1;
      rx_overrun <= rx_valid && !rx_ack;
    end else if (rx_ack && rx_valid) begin
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end
  end

  assign tx_ready = !hold_full;
  assign busy     = (state == ST_ACTIVE);

endmodule
